// File: rtl/bp_update_scheduler.sv
// Gshare predictor write sequencer: buffers EX resolution updates in a FIFO and issues BTB/PHT writes.
// Owns the global history register and runs a table-clear sweep after reset or on clear_req.
module bp_update_scheduler #(
  parameter int         ENTRY_BIT = 5,
  parameter int         DEPTH     = 4,
  parameter logic [1:0] PHT_INIT  = 2'b01
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         upd_valid,
  output logic                         upd_ready,
  input  logic [31:0]                  upd_pc,
  input  logic [31:0]                  upd_target,
  input  logic                         upd_is_branch,
  input  logic                         upd_taken,
  input  logic [ENTRY_BIT-1:0]         upd_bhsr,
  input  logic                         upd_write_btb,
  input  logic                         drain_hold,
  input  logic                         clear_req,
  output logic                         busy,
  output logic [ENTRY_BIT-1:0]         ghr,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         btb_we,
  output logic [ENTRY_BIT-1:0]         btb_widx,
  output logic                         btb_wval,
  output logic [29-ENTRY_BIT:0]        btb_wtag,
  output logic [31:0]                  btb_wtarget,
  output logic                         btb_wis_branch,
  output logic [ENTRY_BIT-1:0]         pht_ridx,
  input  logic [1:0]                   pht_rdata,
  output logic                         pht_we,
  output logic [ENTRY_BIT-1:0]         pht_widx,
  output logic [1:0]                   pht_wdata
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic {SWEEP, RUN} state_t;

  // Byte-offset bits of the PC never reach the tables, so only pc[31:2] is stored.
  typedef struct packed {
    logic [29:0]          pc_hi;
    logic [31:0]          target;
    logic                 is_branch;
    logic                 taken;
    logic [ENTRY_BIT-1:0] bhsr;
    logic                 write_btb;
  } upd_t;

  state_t               state_q, state_d;
  logic [ENTRY_BIT-1:0] sweep_idx_q, sweep_idx_d;
  logic [ENTRY_BIT-1:0] ghr_q, ghr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  upd_t                 mem_q [DEPTH];
  upd_t                 head, in_pkt;
  logic                 enq, deq;
  logic [ENTRY_BIT-1:0] head_idx, head_pidx;
  logic                 pc_lsb_unused;

  assign pc_lsb_unused = ^upd_pc[1:0];
  assign busy          = (state_q == SWEEP);
  assign ghr           = ghr_q;
  assign fifo_count    = count_q;
  assign head          = mem_q[rd_ptr_q];
  assign head_idx      = head.pc_hi[ENTRY_BIT-1:0];
  assign head_pidx     = head_idx ^ head.bhsr;
  assign in_pkt        = '{pc_hi: upd_pc[31:2], target: upd_target, is_branch: upd_is_branch,
                           taken: upd_taken, bhsr: upd_bhsr, write_btb: upd_write_btb};

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? 2'b11 : c + 2'b01;
    else    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    ghr_d       = ghr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    upd_ready   = (state_q == RUN) && (count_q < DEPTH_C);
    enq         = upd_valid && upd_ready && !clear_req;
    deq         = (state_q == RUN) && (count_q != '0) && !drain_hold && !clear_req;

    btb_we         = 1'b0;
    btb_widx       = head_idx;
    btb_wval       = 1'b1;
    btb_wtag       = head.pc_hi[29:ENTRY_BIT];
    btb_wtarget    = head.target;
    btb_wis_branch = head.is_branch;
    pht_we         = 1'b0;
    pht_ridx       = head_pidx;
    pht_widx       = head_pidx;
    pht_wdata      = sat_step(pht_rdata, head.taken);

    case (state_q)
      SWEEP: begin
        btb_we         = 1'b1;
        pht_we         = 1'b1;
        btb_widx       = sweep_idx_q;
        pht_widx       = sweep_idx_q;
        btb_wval       = 1'b0;
        btb_wtag       = '0;
        btb_wtarget    = '0;
        btb_wis_branch = 1'b0;
        pht_wdata      = PHT_INIT;
        if (clear_req) begin
          sweep_idx_d = '0;
        end else if (sweep_idx_q == '1) begin
          state_d     = RUN;
          sweep_idx_d = '0;
        end else begin
          sweep_idx_d = sweep_idx_q + 1'b1;
        end
      end
      RUN: begin
        if (clear_req) begin
          // Queued updates are discarded: they describe a table about to be wiped.
          state_d     = SWEEP;
          sweep_idx_d = '0;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          count_d     = '0;
          ghr_d       = '0;
        end else begin
          if (enq) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
            if (upd_is_branch) ghr_d = {ghr_q[ENTRY_BIT-2:0], upd_taken};
          end
          if (deq) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            pht_we   = head.is_branch;
            btb_we   = head.write_btb;
          end
          count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
        end
      end
      default: state_d = SWEEP;
    endcase

    if (!reset) begin
      btb_we = 1'b0;
      pht_we = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SWEEP;
      sweep_idx_q <= '0;
      ghr_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      ghr_q       <= ghr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= in_pkt;
  end

endmodule
